wb_mem_2_ppfifo: RTL and testbench
==================================

WB_MEM_2_PPFIFO -- requirements
Module: wb_mem_2_ppfifo

Interface
REQ-001 SHALL have no parameters; widths fixed: data and address 32 bits, PPFIFO size 24 bits.
REQ-002 SHALL have these ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_enable  in  1  core enable
- i_memory_0_base, i_memory_1_base  in  32  bank word base address
- i_memory_0_size, i_memory_1_size  in  32  bank length in words
- i_memory_0_new_data, i_memory_1_new_data  in  1  pulse: bank refilled
- o_memory_0_count, o_memory_1_count  out  32  words left to read (size-ptr)
- o_memory_0_empty, o_memory_1_empty  out  1  count==0
- o_read_finished  out  1  one-cycle pulse: bank drained
- o_mem_we, o_mem_stb, o_mem_cyc  out  1  Wishbone master controls
- o_mem_sel  out  4  byte select
- o_mem_adr  out  32  word address
- o_mem_dat  out  32  write data, unused
- i_mem_dat  in  32  read data
- i_mem_ack  in  1  slave acknowledge
- i_mem_int  in  1  unused
- i_ppfifo_rdy  in  2  per-side PPFIFO write ready
- o_ppfifo_act  out  2  per-side write activate, at most one bit high
- i_ppfifo_size  in  24  words the active side accepts
- o_ppfifo_stb  out  1  write strobe
- o_ppfifo_data  out  32  write data

Function
REQ-003 Per-bank 32-bit ptr; count = size - ptr, modulo 2^32; empty = (count==0); o_mem_adr = active base + active ptr.
REQ-004 o_mem_we SHALL be 0, o_mem_sel 4'hF, and o_mem_dat 0 at all times.
REQ-005 States: IDLE, GET_MEMORY_BLOCK, READ_REQ, READ_WAIT, FINISHED.
REQ-006 IDLE: cyc=stb=0; i_enable=1 -> GET_MEMORY_BLOCK.
REQ-007 GET_MEMORY_BLOCK: select bank 0 if count0>0, else bank 1 if count1>0, else stay; i_enable=0 -> IDLE.
REQ-008 PPFIFO grab, independent of state: when i_enable=1, act==0 and rdy!=0, set act to bit 0 if rdy[0], else bit 1; clear the word counter the same edge.
REQ-009 READ_REQ: with act!=0 and counter<i_ppfifo_size, assert cyc=stb=1 -> READ_WAIT. With act==0, hold cyc=stb=0 and wait.
REQ-010 READ_WAIT: on the edge sampling i_mem_ack=1 with stb=1: deassert stb, latch i_mem_dat into o_ppfifo_data, pulse o_ppfifo_stb next cycle, increment counter and active ptr.
REQ-011 After each ack: counter==size -> act=0, cyc=0; count==0 -> FINISHED; else -> READ_REQ.
REQ-012 One Wishbone read in flight; cyc held between beats while the PPFIFO has room.
REQ-013 FINISHED: cyc=stb=0; pulse o_read_finished one cycle; release act if counter>0 (partial flush); -> GET_MEMORY_BLOCK.
REQ-014 i_memory_N_new_data SHALL clear ptr[N] and override a same-cycle increment; on the active bank the read restarts from offset 0.
REQ-015 size=0 bank is empty and never selected.
REQ-016 i_enable falling mid-transfer SHALL complete the current beat, then not start another from READ_REQ.

Reset
REQ-017 rst SHALL asynchronously force: state=IDLE; ptrs=0; counter=0; cyc=stb=we=0; sel=4'hF; o_mem_dat=0; act=2'b00; o_ppfifo_stb=0; o_ppfifo_data=0; o_read_finished=0.
REQ-018 A reset mid-burst SHALL drop cyc/stb/act without waiting for ack; a later ack is ignored.

Verification
REQ-019 base0=0x100, size0=4, size1=0, rdy=01, fifo size 16, ack 1-cycle -> adr 0x100..0x103, 4 stb, data in order, act released, one o_read_finished, empty0=1.
REQ-020 size0=8, fifo size 4, rdy=11 -> 4 words into side 0, act->00, regrab side 1, 4 more words, one finished pulse.
REQ-021 size0=size1=2, both loaded -> bank 0 drained, then bank 1 at base1, two finished pulses.
REQ-022 new_data0 pulsed after 2 of 4 words -> ptr0=0, reads restart at base0, total 6 strobes.
REQ-023 rst asserted while stb=1 awaiting ack -> outputs at reset values before the next clock edge; no o_ppfifo_stb.
REQ-024 ack delayed 5 cycles -> stb/cyc/adr held stable; exactly one strobe per ack.

Source files
------------

// File: rtl/wb_mem_2_ppfifo.sv
// wb_mem_2_ppfifo
//   Drains two memory banks over a Wishbone master read port into a
//   ping-pong FIFO. The banks are refilled externally. Each bank keeps a word
//   pointer. The FSM picks bank 0 first, then bank 1, and issues one read at a
//   time. Every returned word is pushed into the currently held PPFIFO side.
//
// Ports
//   clk, rst                         clock, asynchronous active-high reset
//   i_enable                         core enable
//   i_memory_N_base / _size          bank word base address / length in words
//   i_memory_N_new_data              pulse: bank refilled, pointer rewinds
//   o_memory_N_count / _empty        words left in bank / no words left
//   o_read_finished                  one-cycle pulse when a bank is drained
//   o_mem_*, i_mem_*                 Wishbone master (read only)
//   i_ppfifo_rdy, o_ppfifo_act       PPFIFO side ready / side held
//   i_ppfifo_size                    words the held side accepts
//   o_ppfifo_stb, o_ppfifo_data      PPFIFO write strobe / data
module wb_mem_2_ppfifo (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  input  logic [31:0] i_memory_0_base,
  input  logic [31:0] i_memory_0_size,
  input  logic        i_memory_0_new_data,
  input  logic [31:0] i_memory_1_base,
  input  logic [31:0] i_memory_1_size,
  input  logic        i_memory_1_new_data,
  output logic [31:0] o_memory_0_count,
  output logic        o_memory_0_empty,
  output logic [31:0] o_memory_1_count,
  output logic        o_memory_1_empty,
  output logic        o_read_finished,
  output logic        o_mem_we,
  output logic        o_mem_stb,
  output logic        o_mem_cyc,
  output logic [3:0]  o_mem_sel,
  output logic [31:0] o_mem_adr,
  output logic [31:0] o_mem_dat,
  input  logic [31:0] i_mem_dat,
  input  logic        i_mem_ack,
  input  logic        i_mem_int,
  input  logic [1:0]  i_ppfifo_rdy,
  output logic [1:0]  o_ppfifo_act,
  input  logic [23:0] i_ppfifo_size,
  output logic        o_ppfifo_stb,
  output logic [31:0] o_ppfifo_data
);

  localparam logic [2:0] IDLE             = 3'd0;
  localparam logic [2:0] GET_MEMORY_BLOCK = 3'd1;
  localparam logic [2:0] READ_REQ         = 3'd2;
  localparam logic [2:0] READ_WAIT        = 3'd3;
  localparam logic [2:0] FINISHED         = 3'd4;

  logic [2:0]  r_state;
  logic [31:0] r_ptr0;
  logic [31:0] r_ptr1;
  logic        r_bank;
  logic [23:0] r_count;
  logic [1:0]  r_act;
  logic        r_cyc;
  logic        r_stb;
  logic        r_ppfifo_stb;
  logic [31:0] r_ppfifo_data;
  logic        r_read_finished;

  logic        w_beat;
  logic [31:0] w_ptr0_next;
  logic [31:0] w_ptr1_next;
  logic [31:0] w_count_after;
  logic [23:0] w_count_inc;
  logic        w_unused;

  assign w_unused = i_mem_int;

  // A beat completes on the edge that samples ack while our strobe is up.
  assign w_beat = (r_state == READ_WAIT) && r_stb && i_mem_ack;

  // A refill pulse rewinds the pointer and wins over a same-cycle increment.
  always_comb begin
    w_ptr0_next = r_ptr0;
    w_ptr1_next = r_ptr1;
    if (w_beat) begin
      if (r_bank) w_ptr1_next = r_ptr1 + 32'd1;
      else        w_ptr0_next = r_ptr0 + 32'd1;
    end
    if (i_memory_0_new_data) w_ptr0_next = '0;
    if (i_memory_1_new_data) w_ptr1_next = '0;
  end

  // Words left in the active bank once this edge's pointer update lands.
  assign w_count_after = r_bank ? (i_memory_1_size - w_ptr1_next)
                                : (i_memory_0_size - w_ptr0_next);
  assign w_count_inc   = r_count + 24'd1;

  assign o_memory_0_count = i_memory_0_size - r_ptr0;
  assign o_memory_1_count = i_memory_1_size - r_ptr1;
  assign o_memory_0_empty = (o_memory_0_count == 32'd0);
  assign o_memory_1_empty = (o_memory_1_count == 32'd0);

  assign o_mem_adr = r_bank ? (i_memory_1_base + r_ptr1) : (i_memory_0_base + r_ptr0);
  assign o_mem_we  = 1'b0;
  assign o_mem_sel = 4'hF;
  assign o_mem_dat = 32'd0;
  assign o_mem_cyc = r_cyc;
  assign o_mem_stb = r_stb;

  assign o_ppfifo_act    = r_act;
  assign o_ppfifo_stb    = r_ppfifo_stb;
  assign o_ppfifo_data   = r_ppfifo_data;
  assign o_read_finished = r_read_finished;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= IDLE;
      r_ptr0          <= '0;
      r_ptr1          <= '0;
      r_bank          <= 1'b0;
      r_count         <= '0;
      r_act           <= 2'b00;
      r_cyc           <= 1'b0;
      r_stb           <= 1'b0;
      r_ppfifo_stb    <= 1'b0;
      r_ppfifo_data   <= '0;
      r_read_finished <= 1'b0;
    end else begin
      r_ppfifo_stb    <= 1'b0;
      r_read_finished <= 1'b0;
      r_ptr0          <= w_ptr0_next;
      r_ptr1          <= w_ptr1_next;

      case (r_state)
        IDLE: begin
          r_cyc <= 1'b0;
          r_stb <= 1'b0;
          if (i_enable) r_state <= GET_MEMORY_BLOCK;
        end
        GET_MEMORY_BLOCK: begin
          if (!i_enable) begin
            r_state <= IDLE;
          end else if (o_memory_0_count != 32'd0) begin
            r_bank  <= 1'b0;
            r_state <= READ_REQ;
          end else if (o_memory_1_count != 32'd0) begin
            r_bank  <= 1'b1;
            r_state <= READ_REQ;
          end
        end
        READ_REQ: begin
          if (!i_enable) begin
            // Enable dropped between beats: stop here, nothing in flight.
            r_cyc   <= 1'b0;
            r_state <= IDLE;
          end else if ((r_act != 2'b00) && (r_count < i_ppfifo_size)) begin
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_state <= READ_WAIT;
          end else begin
            r_cyc <= 1'b0;
          end
        end
        READ_WAIT: begin
          if (w_beat) begin
            r_stb         <= 1'b0;
            r_ppfifo_data <= i_mem_dat;
            r_ppfifo_stb  <= 1'b1;
            r_count       <= w_count_inc;
            // A full side is handed back; cyc stays up only while there is room.
            if (w_count_inc == i_ppfifo_size) begin
              r_act <= 2'b00;
              r_cyc <= 1'b0;
            end
            if (w_count_after == 32'd0) begin
              r_cyc   <= 1'b0;
              r_state <= FINISHED;
            end else begin
              r_state <= READ_REQ;
            end
          end
        end
        FINISHED: begin
          r_cyc           <= 1'b0;
          r_stb           <= 1'b0;
          r_read_finished <= 1'b1;
          // Partially filled side is flushed so the reader sees it now.
          if (r_count != 24'd0) r_act <= 2'b00;
          r_state <= GET_MEMORY_BLOCK;
        end
        default: begin
          r_cyc   <= 1'b0;
          r_stb   <= 1'b0;
          r_state <= IDLE;
        end
      endcase

      // Side grab runs regardless of state; it only fires with no side held,
      // so it never collides with a release above.
      if (i_enable && (r_act == 2'b00) && (i_ppfifo_rdy != 2'b00)) begin
        r_act   <= i_ppfifo_rdy[0] ? 2'b01 : 2'b10;
        r_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wb_mem_2_ppfifo.sv
// Directed bench for wb_mem_2_ppfifo: a Wishbone slave with programmable ack
// latency returns 0xDA000000 | address, and a PPFIFO model drops ready on a
// side once it is released. Beats are logged and compared to hand lists.
module tb_wb_mem_2_ppfifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_enable = 1'b0;
  logic [31:0] base0 = '0, base1 = '0, size0 = '0, size1 = '0;
  logic        nd0 = 1'b0;
  logic        nd1 = 1'b0;
  logic [31:0] o_memory_0_count, o_memory_1_count;
  logic        o_memory_0_empty, o_memory_1_empty, o_read_finished;
  logic        o_mem_we, o_mem_stb, o_mem_cyc;
  logic [3:0]  o_mem_sel;
  logic [31:0] o_mem_adr, o_mem_dat;
  logic [31:0] i_mem_dat = '0;
  logic        i_mem_ack = 1'b0;
  logic        i_mem_int = 1'b0;
  logic [1:0]  i_ppfifo_rdy = 2'b00;
  logic [1:0]  o_ppfifo_act;
  logic [23:0] fifo_size = 24'd16;
  logic        o_ppfifo_stb;
  logic [31:0] o_ppfifo_data;

  always #5 clk = ~clk;

  wb_mem_2_ppfifo dut (
    .clk(clk), .rst(rst), .i_enable(i_enable),
    .i_memory_0_base(base0), .i_memory_0_size(size0), .i_memory_0_new_data(nd0),
    .i_memory_1_base(base1), .i_memory_1_size(size1), .i_memory_1_new_data(nd1),
    .o_memory_0_count(o_memory_0_count), .o_memory_0_empty(o_memory_0_empty),
    .o_memory_1_count(o_memory_1_count), .o_memory_1_empty(o_memory_1_empty),
    .o_read_finished(o_read_finished),
    .o_mem_we(o_mem_we), .o_mem_stb(o_mem_stb), .o_mem_cyc(o_mem_cyc),
    .o_mem_sel(o_mem_sel), .o_mem_adr(o_mem_adr), .o_mem_dat(o_mem_dat),
    .i_mem_dat(i_mem_dat), .i_mem_ack(i_mem_ack), .i_mem_int(i_mem_int),
    .i_ppfifo_rdy(i_ppfifo_rdy), .o_ppfifo_act(o_ppfifo_act),
    .i_ppfifo_size(fifo_size), .o_ppfifo_stb(o_ppfifo_stb), .o_ppfifo_data(o_ppfifo_data)
  );

  int n_cmp = 0;
  int n_err = 0;
  int ack_delay = 1;
  bit hold_chk = 1'b0;
  bit nd_mode = 1'b0;
  bit nd_done = 1'b0;
  logic [1:0]  rdy_cfg = 2'b00;
  logic [1:0]  act_prev = 2'b00;
  logic        stb_prev = 1'b0;
  int          wcnt = 0;
  logic [31:0] hold_adr = '0;
  logic [31:0] log_adr [0:15];
  logic [31:0] log_dat [0:15];
  logic [1:0]  log_act [0:15];
  int n_ack = 0, n_stb = 0, n_fin = 0, n_memstb = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Slave, PPFIFO model and monitors, all sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      i_mem_ack = 1'b0; i_mem_dat = '0; wcnt = 0;
      i_ppfifo_rdy = rdy_cfg; act_prev = 2'b00; stb_prev = 1'b0;
      n_ack = 0; n_stb = 0; n_fin = 0; n_memstb = 0;
      nd0 = 1'b0; nd_done = 1'b0;
    end else begin
      for (int s = 0; s < 2; s++)
        if (act_prev[s] && !o_ppfifo_act[s]) i_ppfifo_rdy[s] = 1'b0;
      act_prev = o_ppfifo_act;
      if (o_mem_stb && !stb_prev) n_memstb++;
      stb_prev = o_mem_stb;
      if (o_ppfifo_stb) begin
        if (n_stb < 16) log_dat[n_stb] = o_ppfifo_data;
        n_stb++;
      end
      if (o_read_finished) n_fin++;
      nd0 = 1'b0;
      if (nd_mode && !nd_done && n_stb == 2) begin
        nd0 = 1'b1;
        nd_done = 1'b1;
      end
      if (o_mem_cyc && o_mem_stb && !i_mem_ack) begin
        if (wcnt == 0) hold_adr = o_mem_adr;
        else if (hold_chk) begin
          chk("hold_adr", o_mem_adr, hold_adr);
          chk("hold_cyc", {31'd0, o_mem_cyc}, 32'd1);
        end
        wcnt++;
        if (wcnt >= ack_delay) begin
          i_mem_ack = 1'b1;
          i_mem_dat = 32'hDA00_0000 | o_mem_adr;
          if (n_ack < 16) begin
            log_adr[n_ack] = o_mem_adr;
            log_act[n_ack] = o_ppfifo_act;
          end
          n_ack++;
        end
      end else begin
        i_mem_ack = 1'b0;
        wcnt = 0;
      end
    end
  end

  task automatic start_test(input logic [31:0] b0, input logic [31:0] s0,
                            input logic [31:0] b1, input logic [31:0] s1,
                            input logic [1:0] rdy, input logic [23:0] fsz, input int dly);
    @(posedge clk); #2;
    rst = 1'b1; i_enable = 1'b0;
    base0 = b0; size0 = s0; base1 = b1; size1 = s1;
    rdy_cfg = rdy; fifo_size = fsz; ack_delay = dly;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #2 i_enable = 1'b1;
  endtask

  task automatic wait_fin(input int n, input int maxc);
    int c;
    c = 0;
    while (n_fin < n && c < maxc) begin
      @(posedge clk);
      c++;
    end
    repeat (8) @(posedge clk);
    #1;
    if (c >= maxc) chk("timeout_fin", n_fin, n);
  endtask

  task automatic chk_beat(input string tag, input int i, input logic [31:0] adr, input logic [1:0] act);
    chk($sformatf("%s adr%0d", tag, i), log_adr[i], adr);
    chk($sformatf("%s dat%0d", tag, i), log_dat[i], 32'hDA00_0000 | adr);
    chk($sformatf("%s act%0d", tag, i), {30'd0, log_act[i]}, {30'd0, act});
  endtask

  initial begin
    int c;
    rdy_cfg = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst cyc", {31'd0, o_mem_cyc}, 32'd0);
    chk("rst stb", {31'd0, o_mem_stb}, 32'd0);
    chk("rst we", {31'd0, o_mem_we}, 32'd0);
    chk("rst sel", {28'd0, o_mem_sel}, 32'hF);
    chk("rst mdat", o_mem_dat, 32'd0);
    chk("rst act", {30'd0, o_ppfifo_act}, 32'd0);
    chk("rst pstb", {31'd0, o_ppfifo_stb}, 32'd0);
    chk("rst pdat", o_ppfifo_data, 32'd0);
    chk("rst fin", {31'd0, o_read_finished}, 32'd0);

    // Single bank, four words, one side of sixteen.
    start_test(32'h100, 32'd4, 32'h0, 32'd0, 2'b01, 24'd16, 1);
    wait_fin(1, 300);
    chk("t1 memstb", n_memstb, 32'd4);
    chk("t1 pstb", n_stb, 32'd4);
    chk("t1 fin", n_fin, 32'd1);
    chk_beat("t1", 0, 32'h100, 2'b01);
    chk_beat("t1", 1, 32'h101, 2'b01);
    chk_beat("t1", 2, 32'h102, 2'b01);
    chk_beat("t1", 3, 32'h103, 2'b01);
    chk("t1 act", {30'd0, o_ppfifo_act}, 32'd0);
    chk("t1 empty0", {31'd0, o_memory_0_empty}, 32'd1);
    chk("t1 count0", o_memory_0_count, 32'd0);
    chk("t1 we", {31'd0, o_mem_we}, 32'd0);

    // Eight words through a four-word side: side 0 fills, side 1 takes the rest.
    start_test(32'h200, 32'd8, 32'h0, 32'd0, 2'b11, 24'd4, 1);
    wait_fin(1, 400);
    chk("t2 pstb", n_stb, 32'd8);
    chk("t2 fin", n_fin, 32'd1);
    chk_beat("t2", 0, 32'h200, 2'b01);
    chk_beat("t2", 3, 32'h203, 2'b01);
    chk_beat("t2", 4, 32'h204, 2'b10);
    chk_beat("t2", 7, 32'h207, 2'b10);
    chk("t2 act", {30'd0, o_ppfifo_act}, 32'd0);

    // Both banks loaded: bank 0 then bank 1.
    start_test(32'h300, 32'd2, 32'h400, 32'd2, 2'b11, 24'd16, 1);
    wait_fin(2, 400);
    chk("t3 pstb", n_stb, 32'd4);
    chk("t3 fin", n_fin, 32'd2);
    chk_beat("t3", 0, 32'h300, 2'b01);
    chk_beat("t3", 1, 32'h301, 2'b01);
    chk_beat("t3", 2, 32'h400, 2'b10);
    chk_beat("t3", 3, 32'h401, 2'b10);
    chk("t3 empty1", {31'd0, o_memory_1_empty}, 32'd1);

    // Refill after two words: reads restart from the base.
    nd_mode = 1'b1;
    start_test(32'h500, 32'd4, 32'h0, 32'd0, 2'b01, 24'd16, 1);
    wait_fin(1, 400);
    nd_mode = 1'b0;
    chk("t4 memstb", n_memstb, 32'd6);
    chk("t4 pstb", n_stb, 32'd6);
    chk("t4 fin", n_fin, 32'd1);
    chk_beat("t4", 1, 32'h501, 2'b01);
    chk_beat("t4", 2, 32'h500, 2'b01);
    chk_beat("t4", 5, 32'h503, 2'b01);

    // Slow slave: bus held stable for the whole wait.
    hold_chk = 1'b1;
    start_test(32'h600, 32'd2, 32'h0, 32'd0, 2'b01, 24'd16, 5);
    wait_fin(1, 400);
    hold_chk = 1'b0;
    chk("t5 ack", n_ack, 32'd2);
    chk("t5 pstb", n_stb, 32'd2);
    chk("t5 fin", n_fin, 32'd1);
    chk_beat("t5", 0, 32'h600, 2'b01);
    chk_beat("t5", 1, 32'h601, 2'b01);

    // Reset while a read waits for ack.
    start_test(32'h700, 32'd4, 32'h0, 32'd0, 2'b01, 24'd16, 5);
    c = 0;
    while (!o_mem_stb && c < 50) begin
      @(posedge clk); #2;
      c++;
    end
    chk("t6 stb seen", {31'd0, o_mem_stb}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t6 cyc", {31'd0, o_mem_cyc}, 32'd0);
    chk("t6 stb", {31'd0, o_mem_stb}, 32'd0);
    chk("t6 act", {30'd0, o_ppfifo_act}, 32'd0);
    chk("t6 pstb", {31'd0, o_ppfifo_stb}, 32'd0);
    chk("t6 count0", o_memory_0_count, 32'd4);
    i_enable = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("t6 ack", n_ack, 32'd0);
    chk("t6 no pstb", n_stb, 32'd0);
    chk("t6 cyc idle", {31'd0, o_mem_cyc}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
